tc_scan_ctrl: RTL and testbench
===============================

# tc_scan_ctrl

Sequencer for the timer/counter bank. It serializes processor configuration writes into the enable/type register file (`tcEnableAndType`) and, on each timebase tick, scans the 8 timer/counter slots round-robin. For every enabled slot it issues one service request to the shared timer/counter update unit. It sits between the processor I/O decode, the enable/type register file and the shared preset/accumulator datapath.

## Interface
- `TC_NUM`, 8: number of timer/counter slots (= `tcNumbers`)
- `TC_ADDR_LEN`, 3: slot address width (= `tcAddrLen`)
- `TC_TYPE_LEN`, 2: type field width (= `tcTypeLen`)

- `clk` in 1: single clock; all state updates on rising edge
- `reset` in 1: synchronous, active-low reset
- `cfgReq` in 1: processor config request (level, held until `cfgAck`)
- `cfgAddr` in TC_ADDR_LEN: slot to configure
- `cfgEn` in 1: enable value to write
- `cfgType` in TC_TYPE_LEN: type value to write
- `cfgAck` out 1: one-cycle pulse, write performed
- `entypeEn` out 1: write strobe to register file
- `tcAddr` out TC_ADDR_LEN: register file write address
- `enOut` out 1: enable data to register file
- `typeOut` out TC_TYPE_LEN: type data to register file
- `enVec` in TC_NUM: per-slot enables read back from register file
- `typeVec` in TC_NUM*TC_TYPE_LEN: per-slot types, slot i at [i*TC_TYPE_LEN +: TC_TYPE_LEN]
- `tick` in 1: timebase pulse, starts a scan pass
- `svcReq` out 1: service request to shared update unit
- `svcAddr` out TC_ADDR_LEN: slot being serviced
- `svcType` out TC_TYPE_LEN: type of slot being serviced
- `svcDone` in 1: update unit completion (one-cycle pulse)
- `scanBusy` out 1: scan pass in progress
- `overrun` out 1: sticky; tick lost

## Operation
- States: IDLE, CFG, SCAN, WAIT. `ptr` is TC_ADDR_LEN bits. `tickPend` is 1 bit.
- IDLE:
  - `cfgReq` → CFG. Config has priority over scan start.
  - Else if `tickPend` → SCAN, `ptr`=0, clear `tickPend`, `scanBusy`=1.
- CFG (exactly 1 cycle):
  - `entypeEn`=1, `cfgAck`=1; address and data are the registered copies of the `cfg*` inputs.
  - Next state is SCAN if `scanBusy`, else IDLE.
- SCAN:
  - If `cfgReq` → CFG. Config is accepted only at slot boundaries and never while in WAIT.
  - Else if `enVec[ptr]` → WAIT, asserting `svcReq` with `svcAddr`=`ptr` and `svcType`=`typeVec[ptr]`, both latched.
  - Else skip the slot: `ptr`+1, or end the pass when `ptr`=TC_NUM-1.
- WAIT:
  - Hold `svcReq`, `svcAddr` and `svcType` stable until `svcDone`.
  - On `svcDone`: deassert `svcReq`. If `ptr`=TC_NUM-1, end the pass → IDLE, `scanBusy`=0. Else `ptr`+1 → SCAN.
- Tick handling:
  - `tick` sets `tickPend`.
  - `tick` while `tickPend` is already 1 sets `overrun` (held until reset); the tick is dropped.
  - If `tick` arrives in the same cycle IDLE consumes `tickPend`, `tickPend` is re-set and no overrun is flagged.
- `svcDone` outside WAIT is ignored.
- Pointer wrap: `ptr` never increments past TC_NUM-1. Each pass starts at 0.

## Timing
- Reset (`reset`=0 at edge): state IDLE, `ptr`=0, `tickPend`=0. All outputs are 0: `cfgAck`, `entypeEn`, `tcAddr`, `enOut`, `typeOut`, `svcReq`, `svcAddr`, `svcType`, `scanBusy`, `overrun`.
- Reset mid-scan or mid-WAIT aborts immediately. `svcReq` drops the next cycle and no ack is owed.
- All outputs are registered.
- Config latency:
  - `cfgReq` seen in IDLE → `entypeEn`/`cfgAck` on the following cycle.
  - Worst case during a scan: one full service wait plus one cycle.
- `enVec`/`typeVec` are combinational from the register file. A config write in cycle N is visible to SCAN in cycle N+1.
- Scan cost: 1 cycle per disabled slot; 1 cycle plus the service latency per enabled slot.
- Tick-to-`svcReq` minimum: tick at N, `tickPend` at N+1, SCAN at N+2, `svcReq` at N+3 for slot 0 if enabled.

## Structure
- Shared defines package holds `tcNumbers`, `tcAddrLen`, `tcTypeLen` and the 2-bit state encodings (`TCS_IDLE`, `TCS_CFG`, `TCS_SCAN`, `TCS_WAIT`). Parameters default from them.
- Single module, no sub-modules.
- The tick/overrun latch stays inline; it is too small to split out.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `tick`=1 → all outputs 0, `overrun`=0 after release.
- Config write: `cfgReq`=1, addr 5, en 1, type 2'b10 → one-cycle `entypeEn`=1, `tcAddr`=5, `enOut`=1, `typeOut`=2'b10, with `cfgAck` in the same cycle.
- Scan: slots 1, 4 and 7 enabled, `svcDone` 3 cycles after each `svcReq` → requests in order to addr 1, 4, 7 with the matching types. Pass takes 5 skip cycles plus 3×(1+3) cycles, then `scanBusy`=0.
- Config during scan: `cfgReq` raised while WAIT on slot 1 → write occurs only after `svcDone`, then the scan resumes at slot 2. A write disabling slot 4 causes slot 4 to be skipped.
- Overrun: second `tick` while `tickPend`=1 → `overrun`=1 and stays 1; only one further pass runs after the current one.
- Reset mid-WAIT: assert `reset`=0 while `svcReq`=1 → next cycle `svcReq`=0, state IDLE, `ptr`=0.

Source files
------------

// File: rtl/tc_scan_ctrl_pkg.sv
// Shared defines for the timer/counter bank: slot geometry and scan sequencer state encodings.
package tc_scan_ctrl_pkg;

    localparam int unsigned tcNumbers = 8;
    localparam int unsigned tcAddrLen = 3;
    localparam int unsigned tcTypeLen = 2;

    typedef enum logic [1:0] {
        TCS_IDLE = 2'd0,
        TCS_CFG  = 2'd1,
        TCS_SCAN = 2'd2,
        TCS_WAIT = 2'd3
    } tcs_state_e;

endpackage

// File: rtl/tc_scan_ctrl.sv
// Timer/counter bank sequencer: serializes processor config writes into the enable/type
// register file and, per timebase tick, walks all slots issuing one service request per enabled slot.
module tc_scan_ctrl
    import tc_scan_ctrl_pkg::*;
#(
    parameter int unsigned TC_NUM      = tcNumbers,
    parameter int unsigned TC_ADDR_LEN = tcAddrLen,
    parameter int unsigned TC_TYPE_LEN = tcTypeLen
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfgReq,
    input  logic [TC_ADDR_LEN-1:0]        cfgAddr,
    input  logic                          cfgEn,
    input  logic [TC_TYPE_LEN-1:0]        cfgType,
    output logic                          cfgAck,
    output logic                          entypeEn,
    output logic [TC_ADDR_LEN-1:0]        tcAddr,
    output logic                          enOut,
    output logic [TC_TYPE_LEN-1:0]        typeOut,
    input  logic [TC_NUM-1:0]             enVec,
    input  logic [TC_NUM*TC_TYPE_LEN-1:0] typeVec,
    input  logic                          tick,
    output logic                          svcReq,
    output logic [TC_ADDR_LEN-1:0]        svcAddr,
    output logic [TC_TYPE_LEN-1:0]        svcType,
    input  logic                          svcDone,
    output logic                          scanBusy,
    output logic                          overrun
);

    localparam logic [TC_ADDR_LEN-1:0] PtrLast = TC_ADDR_LEN'(TC_NUM - 1);

    tcs_state_e             state;
    logic [TC_ADDR_LEN-1:0] ptr;
    logic                   tick_pend;
    logic                   pend_consume;

    // IDLE takes the pending tick only when no config request is competing for it.
    assign pend_consume = (state == TCS_IDLE) && !cfgReq && tick_pend;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= TCS_IDLE;
            ptr       <= '0;
            tick_pend <= 1'b0;
            cfgAck    <= 1'b0;
            entypeEn  <= 1'b0;
            tcAddr    <= '0;
            enOut     <= 1'b0;
            typeOut   <= '0;
            svcReq    <= 1'b0;
            svcAddr   <= '0;
            svcType   <= '0;
            scanBusy  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            cfgAck   <= 1'b0;
            entypeEn <= 1'b0;

            // A tick landing on the consume cycle re-arms the latch without counting as lost.
            if (tick) begin
                if (tick_pend && !pend_consume) begin
                    overrun <= 1'b1;
                end
                tick_pend <= 1'b1;
            end else if (pend_consume) begin
                tick_pend <= 1'b0;
            end

            unique case (state)
                TCS_IDLE: begin
                    if (cfgReq) begin
                        state    <= TCS_CFG;
                        entypeEn <= 1'b1;
                        cfgAck   <= 1'b1;
                        tcAddr   <= cfgAddr;
                        enOut    <= cfgEn;
                        typeOut  <= cfgType;
                    end else if (tick_pend) begin
                        state    <= TCS_SCAN;
                        ptr      <= '0;
                        scanBusy <= 1'b1;
                    end
                end
                TCS_CFG: begin
                    state <= scanBusy ? TCS_SCAN : TCS_IDLE;
                end
                TCS_SCAN: begin
                    if (cfgReq) begin
                        state    <= TCS_CFG;
                        entypeEn <= 1'b1;
                        cfgAck   <= 1'b1;
                        tcAddr   <= cfgAddr;
                        enOut    <= cfgEn;
                        typeOut  <= cfgType;
                    end else if (enVec[ptr]) begin
                        state   <= TCS_WAIT;
                        svcReq  <= 1'b1;
                        svcAddr <= ptr;
                        svcType <= typeVec[ptr*TC_TYPE_LEN +: TC_TYPE_LEN];
                    end else if (ptr == PtrLast) begin
                        state    <= TCS_IDLE;
                        ptr      <= '0;
                        scanBusy <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                TCS_WAIT: begin
                    if (svcDone) begin
                        svcReq <= 1'b0;
                        if (ptr == PtrLast) begin
                            state    <= TCS_IDLE;
                            ptr      <= '0;
                            scanBusy <= 1'b0;
                        end else begin
                            state <= TCS_SCAN;
                            ptr   <= ptr + 1'b1;
                        end
                    end
                end
                default: state <= TCS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tc_scan_ctrl.sv
// Scoreboard bench for tc_scan_ctrl: directed config/scan/overrun/reset scenarios with a
// register-file model and a fixed-latency service responder.
module tb_tc_scan_ctrl;
    import tc_scan_ctrl_pkg::*;

    localparam int unsigned SvcLat = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfgReq;
    logic [2:0]  cfgAddr;
    logic        cfgEn;
    logic [1:0]  cfgType;
    logic        cfgAck;
    logic        entypeEn;
    logic [2:0]  tcAddr;
    logic        enOut;
    logic [1:0]  typeOut;
    logic [7:0]  enVec;
    logic [15:0] typeVec;
    logic        tick;
    logic        svcReq;
    logic [2:0]  svcAddr;
    logic [1:0]  svcType;
    logic        svcDone;
    logic        scanBusy;
    logic        overrun;

    logic [7:0]  en_rf   = '0;
    logic [15:0] type_rf = '0;
    logic        resp_en = 1'b1;

    logic [4:0]  exp_svc [$];
    logic [5:0]  exp_cfg [$];
    logic [4:0]  svc_e;
    logic [5:0]  cfg_e;
    logic        svc_prev = 1'b0;
    logic        ent_prev = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tc_scan_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .cfgReq   (cfgReq),
        .cfgAddr  (cfgAddr),
        .cfgEn    (cfgEn),
        .cfgType  (cfgType),
        .cfgAck   (cfgAck),
        .entypeEn (entypeEn),
        .tcAddr   (tcAddr),
        .enOut    (enOut),
        .typeOut  (typeOut),
        .enVec    (enVec),
        .typeVec  (typeVec),
        .tick     (tick),
        .svcReq   (svcReq),
        .svcAddr  (svcAddr),
        .svcType  (svcType),
        .svcDone  (svcDone),
        .scanBusy (scanBusy),
        .overrun  (overrun)
    );

    // Enable/type register file model.
    always @(posedge clk) begin
        if (entypeEn) begin
            en_rf[tcAddr]          <= enOut;
            type_rf[tcAddr*2 +: 2] <= typeOut;
        end
    end
    assign enVec   = en_rf;
    assign typeVec = type_rf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Shared update unit: svcReq stays high for SvcLat cycles, svcDone on the last one.
    initial begin
        svcDone = 1'b0;
        forever begin
            @(negedge clk);
            if (svcReq && resp_en && reset) begin
                repeat (SvcLat - 1) @(negedge clk);
                svcDone = 1'b1;
                @(negedge clk);
                svcDone = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on each new service request and each config strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (svcReq && !svc_prev) begin
                if (exp_svc.size() == 0) begin
                    chk("svc_unexpected_addr", {29'd0, svcAddr}, 32'hffff_ffff);
                end else begin
                    svc_e = exp_svc.pop_front();
                    chk("svc_addr", {29'd0, svcAddr}, {29'd0, svc_e[4:2]});
                    chk("svc_type", {30'd0, svcType}, {30'd0, svc_e[1:0]});
                end
            end
            if (entypeEn) begin
                chk("cfg_ack_with_strobe", {31'd0, cfgAck}, 32'd1);
                chk("cfg_not_during_wait", {31'd0, svcReq}, 32'd0);
                chk("cfg_strobe_one_cycle", {31'd0, ent_prev}, 32'd0);
                if (exp_cfg.size() == 0) begin
                    chk("cfg_unexpected_addr", {29'd0, tcAddr}, 32'hffff_ffff);
                end else begin
                    cfg_e = exp_cfg.pop_front();
                    chk("cfg_addr", {29'd0, tcAddr}, {29'd0, cfg_e[5:3]});
                    chk("cfg_en", {31'd0, enOut}, {31'd0, cfg_e[2]});
                    chk("cfg_type", {30'd0, typeOut}, {30'd0, cfg_e[1:0]});
                end
            end
            svc_prev = svcReq;
            ent_prev = entypeEn;
        end
    end

    task automatic cfg_write(input logic [2:0] a, input logic e, input logic [1:0] t,
                             output int lat);
        exp_cfg.push_back({a, e, t});
        cfgAddr = a;
        cfgEn   = e;
        cfgType = t;
        cfgReq  = 1'b1;
        lat     = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cfgAck && lat < 100);
        if (!cfgAck) chk("cfg_ack_timeout", 32'd0, 32'd1);
        cfgReq = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic wait_busy(input logic level, input string name);
        int n = 0;
        while (scanBusy !== level && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (scanBusy !== level) chk(name, {31'd0, scanBusy}, {31'd0, level});
    endtask

    initial begin
        int lat;
        int n;
        int cl;
        int rises;
        int idle_run;
        logic prev_busy;
        logic cfg_started;

        reset   = 1'b0;
        tick    = 1'b1;
        cfgReq  = 1'b0;
        cfgAddr = '0;
        cfgEn   = 1'b0;
        cfgType = '0;

        // Reset held two cycles with tick asserted.
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tick  = 1'b0;
        chk("reset_outputs", {16'd0, cfgAck, entypeEn, tcAddr, enOut, typeOut, svcReq, svcAddr,
                              svcType, scanBusy, overrun}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        repeat (3) @(negedge clk);
        chk("reset_tick_dropped", {31'd0, scanBusy}, 32'd0);

        // Config writes from IDLE.
        cfg_write(3'd5, 1'b1, 2'b10, lat);
        chk("cfg_latency_idle", lat, 32'd1);
        cfg_write(3'd5, 1'b0, 2'b00, lat);
        cfg_write(3'd1, 1'b1, 2'b01, lat);
        cfg_write(3'd4, 1'b1, 2'b11, lat);
        cfg_write(3'd7, 1'b1, 2'b10, lat);
        chk("cfg_latency_idle_last", lat, 32'd1);

        // Scan of slots 1, 4, 7.
        exp_svc.push_back({3'd1, 2'b01});
        exp_svc.push_back({3'd4, 2'b11});
        exp_svc.push_back({3'd7, 2'b10});
        pulse_tick();
        chk("tick_busy_n1", {31'd0, scanBusy}, 32'd0);
        @(negedge clk);
        chk("tick_busy_n2", {31'd0, scanBusy}, 32'd1);
        n = 0;
        while (scanBusy && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("pass_len_147", n, 32'd17);
        chk("svc_queue_drained", exp_svc.size(), 32'd0);

        // Config raised while waiting on slot 1: disables slot 4 once the wait completes.
        exp_svc.push_back({3'd1, 2'b01});
        exp_svc.push_back({3'd7, 2'b10});
        exp_cfg.push_back({3'd4, 1'b0, 2'b00});
        pulse_tick();
        wait_busy(1'b1, "scan_start_timeout");
        n = 0;
        cl = 0;
        cfg_started = 1'b0;
        while (scanBusy && n < 300) begin
            if (!cfg_started && svcReq && svcAddr == 3'd1) begin
                cfgAddr     = 3'd4;
                cfgEn       = 1'b0;
                cfgType     = 2'b00;
                cfgReq      = 1'b1;
                cfg_started = 1'b1;
            end else if (cfgReq) begin
                cl++;
                if (cfgAck) cfgReq = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        chk("cfg_in_scan_issued", {31'd0, cfg_started}, 32'd1);
        chk("cfg_latency_in_wait", cl, 32'd4);
        chk("pass_len_cfg", n, 32'd16);
        chk("cfg_queue_drained", exp_cfg.size(), 32'd0);

        // Enable slot 0, then check tick-to-request latency and overrun.
        cfg_write(3'd0, 1'b1, 2'b01, lat);
        for (int p = 0; p < 2; p++) begin
            exp_svc.push_back({3'd0, 2'b01});
            exp_svc.push_back({3'd1, 2'b01});
            exp_svc.push_back({3'd7, 2'b10});
        end
        pulse_tick();
        n = 1;
        while (!svcReq && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("tick_to_svcreq", n, 32'd3);
        pulse_tick();
        chk("overrun_first_tick", {31'd0, overrun}, 32'd0);
        pulse_tick();
        chk("overrun_second_tick", {31'd0, overrun}, 32'd1);
        rises = 0;
        idle_run = 0;
        prev_busy = scanBusy;
        n = 0;
        while (idle_run < 30 && n < 400) begin
            @(negedge clk);
            n++;
            if (scanBusy && !prev_busy) rises++;
            idle_run = scanBusy ? 0 : idle_run + 1;
            prev_busy = scanBusy;
        end
        chk("overrun_extra_passes", rises, 32'd1);
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);
        chk("overrun_svc_drained", exp_svc.size(), 32'd0);

        // Reset while waiting on slot 0.
        resp_en = 1'b0;
        exp_svc.push_back({3'd0, 2'b01});
        pulse_tick();
        n = 0;
        while (!svcReq && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_svcreq_seen", {31'd0, svcReq}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_svcreq_low", {31'd0, svcReq}, 32'd0);
        chk("abort_busy_low", {31'd0, scanBusy}, 32'd0);
        chk("abort_overrun_clear", {31'd0, overrun}, 32'd0);
        reset   = 1'b1;
        resp_en = 1'b1;
        @(negedge clk);
        exp_svc.push_back({3'd0, 2'b01});
        exp_svc.push_back({3'd1, 2'b01});
        exp_svc.push_back({3'd7, 2'b10});
        pulse_tick();
        wait_busy(1'b1, "post_abort_start_timeout");
        wait_busy(1'b0, "post_abort_end_timeout");
        repeat (5) @(negedge clk);
        chk("final_svc_drained", exp_svc.size(), 32'd0);
        chk("final_cfg_drained", exp_cfg.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench timeout");
    end

endmodule
